bus_timer: RTL and testbench

Memory-mapped machine timer slave on the core's APB-like bus. It holds the 64-bit `mtime` and `mtimecmp` registers and answers core reads and writes with a fixed one-wait-state handshake. It drives the core's `irqTimer` input. It sits directly downstream of the core's bus master port, and its interrupt output feeds back into the core.

---
 rtl/bus_timer.sv | 171 +++++++++++++++++
 tb/tb_bus_timer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_timer.sv
// bus_timer: memory-mapped machine timer holding the 64-bit mtime and mtimecmp
// registers plus a 2-bit ctrl register. It answers an APB-like bus with a fixed
// single wait state and drives a registered, level-sensitive timer interrupt.
module bus_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        select,
  input  logic        enable,
  input  logic        write,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        irqTimer
);

  localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

  // The setup cycle is recognised from IDLE. The first access cycle, seen
  // while in SETUP with enable high, is the single wait state. Its closing edge
  // registers ready and rdata, so the second access cycle is RESP.
  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    RESP
  } state_t;

  typedef enum logic [2:0] {
    REG_MTIME_LO,
    REG_MTIME_HI,
    REG_CMP_LO,
    REG_CMP_HI,
    REG_CTRL,
    REG_NONE
  } reg_t;

  state_t      state, state_next;
  reg_t        dec_reg, cap_reg;
  logic        cap_write;
  logic [31:0] cap_wdata;
  logic [63:0] mtime, mtimecmp;
  logic [1:0]  ctrl;
  logic [15:0] pre;
  logic        access, commit, tick;
  logic [31:0] rd_val;
  logic        unused_addr;

  // Byte lanes inside a word are not decoded.
  assign unused_addr = ^addr[1:0];

  assign access = (state == SETUP) && select && enable;
  assign commit = (state == RESP) && cap_write;
  assign tick   = ctrl[0] && (pre == PRE_MAX);

  // Bus FSM state register.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values, independent of the order of the always blocks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Bus FSM next-state logic; SETUP holds while enable stays low.
  // NOTE: every combinational output gets a default first so that no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (select && !enable) state_next = SETUP;
      SETUP: begin
        if (!select)     state_next = IDLE;
        else if (enable) state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Address decode of the live bus address; anything unmapped is REG_NONE.
  always_comb begin
    dec_reg = REG_NONE;
    if (addr[31:12] == BASE_ADDR[31:12]) begin
      case (addr[11:2])
        10'h000: dec_reg = REG_MTIME_LO;
        10'h001: dec_reg = REG_MTIME_HI;
        10'h002: dec_reg = REG_CMP_LO;
        10'h003: dec_reg = REG_CMP_HI;
        10'h004: dec_reg = REG_CTRL;
        default: dec_reg = REG_NONE;
      endcase
    end
  end

  // Read mux; unmapped offsets and ctrl's upper bits read as zero.
  always_comb begin
    rd_val = '0;
    case (dec_reg)
      REG_MTIME_LO: rd_val = mtime[31:0];
      REG_MTIME_HI: rd_val = mtime[63:32];
      REG_CMP_LO:   rd_val = mtimecmp[31:0];
      REG_CMP_HI:   rd_val = mtimecmp[63:32];
      REG_CTRL:     rd_val = {30'd0, ctrl};
      default:      rd_val = '0;
    endcase
  end

  // Capture the transfer at the end of the wait state for the RESP-edge commit.
  // NOTE: these datapath flops carry no reset; they are only consumed in RESP,
  // which can only be reached through a fresh capture.
  always_ff @(posedge clk) begin
    if (access) begin
      cap_reg   <= dec_reg;
      cap_write <= write;
      cap_wdata <= wdata;
    end
  end

  // Response: ready and rdata are valid for exactly the RESP cycle, then clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready <= 1'b0;
      rdata <= '0;
    end else if (access) begin
      ready <= 1'b1;
      rdata <= rd_val;
    end else begin
      ready <= 1'b0;
      rdata <= '0;
    end
  end

  // Prescaler: counts 0..PRESCALE-1 while counting is enabled, then reloads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         pre <= '0;
    else if (tick)    pre <= '0;
    else if (ctrl[0]) pre <= pre + 16'd1;
  end

  // mtime: a bus write to either word beats a coincident tick, which is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                   mtime <= '0;
    else if (commit && cap_reg == REG_MTIME_LO) mtime[31:0]  <= cap_wdata;
    else if (commit && cap_reg == REG_MTIME_HI) mtime[63:32] <= cap_wdata;
    else if (tick)                              mtime <= mtime + 64'd1;
  end

  // mtimecmp and ctrl are written only by the bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtimecmp <= '1;
      ctrl     <= 2'b11;
    end else if (commit) begin
      case (cap_reg)
        REG_CMP_LO: mtimecmp[31:0]  <= cap_wdata;
        REG_CMP_HI: mtimecmp[63:32] <= cap_wdata;
        REG_CTRL:   ctrl            <= cap_wdata[1:0];
        default:    ;
      endcase
    end
  end

  // Interrupt: registered unsigned compare of the current register values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) irqTimer <= 1'b0;
    else      irqTimer <= ctrl[1] && (mtime >= mtimecmp);
  end

endmodule

// File: tb/tb_bus_timer.sv
// tb_bus_timer: directed bench for bus_timer. Two instances share the bus:
// dut4 counts with PRESCALE=4 and dut1 with PRESCALE=1. Every transfer drives
// inputs on the falling edge and samples outputs on the falling edge.
module tb_bus_timer;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        select = 1'b0;
  logic        enable = 1'b0;
  logic        write = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata4, rdata1;
  logic        ready4, ready1, irq4, irq1;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] rd4, rd1;

  always #5 clk = ~clk;

  bus_timer #(.BASE_ADDR(BASE), .PRESCALE(4)) dut4 (
    .clk(clk), .rst(rst), .addr(addr), .select(select), .enable(enable),
    .write(write), .wdata(wdata), .rdata(rdata4), .ready(ready4), .irqTimer(irq4)
  );

  bus_timer #(.BASE_ADDR(BASE), .PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .addr(addr), .select(select), .enable(enable),
    .write(write), .wdata(wdata), .rdata(rdata1), .ready(ready1), .irqTimer(irq1)
  );

  // One transfer: setup cycle, wait cycle (ready low), RESP cycle (ready high).
  // Leaves select/enable asserted; the next call or idle() releases them.
  task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    select = 1'b1; enable = 1'b0; write = wr; addr = a; wdata = d;
    @(negedge clk);
    enable = 1'b1;
    checks++;
    if (ready4 !== 1'b0 || ready1 !== 1'b0) begin
      errors++;
      $display("FAIL wait_cycle_ready addr=%h got %b/%b want 0/0", a, ready4, ready1);
    end
    @(negedge clk);
    checks++;
    if (ready4 !== 1'b1 || ready1 !== 1'b1) begin
      errors++;
      $display("FAIL resp_cycle_ready addr=%h got %b/%b want 1/1", a, ready4, ready1);
    end
    rd4 = rdata4;
    rd1 = rdata1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      select = 1'b0; enable = 1'b0;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0; select = 1'b0; enable = 1'b0; write = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0; select = 1'b0; enable = 1'b0; write = 1'b0; addr = '0; wdata = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ready4 !== 1'b0 || ready1 !== 1'b0 || irq4 !== 1'b0 || irq1 !== 1'b0 || rdata4 !== 32'h0) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d got ready=%b%b irq=%b%b rdata=%h want zeros",
                 i, ready4, ready1, irq4, irq1, rdata4);
      end
    end
    rst = 1'b1;
    xfer(1'b0, BASE + 32'h00, '0);
    checks++;
    if (rd4 !== 32'h0) begin errors++; $display("FAIL reset_mtime_lo got %h want 00000000", rd4); end
    xfer(1'b0, BASE + 32'h08, '0);
    checks++;
    if (rd4 !== 32'hFFFF_FFFF || rd1 !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL reset_cmp_lo got %h/%h want ffffffff", rd4, rd1);
    end
    xfer(1'b0, BASE + 32'h0C, '0);
    checks++;
    if (rd4 !== 32'hFFFF_FFFF || rd1 !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL reset_cmp_hi got %h/%h want ffffffff", rd4, rd1);
    end
    xfer(1'b0, BASE + 32'h10, '0);
    checks++;
    if (rd4 !== 32'h3 || rd1 !== 32'h3) begin
      errors++; $display("FAIL reset_ctrl got %h/%h want 00000003", rd4, rd1);
    end
    idle(1);
  endtask

  task automatic test_handshake();
    apply_reset();
    xfer(1'b0, BASE + 32'h10, '0);
    checks++;
    if (rd4 !== 32'h3) begin errors++; $display("FAIL handshake_rdata got %h want 00000003", rd4); end
    // select/enable stay high: IDLE must ignore them, and rdata must be back to 0.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ready4 !== 1'b0 || rdata4 !== 32'h0) begin
        errors++;
        $display("FAIL handshake_hold cyc=%0d got ready=%b rdata=%h want 0/00000000", i, ready4, rdata4);
      end
    end
    idle(1);
  endtask

  task automatic test_count_carry();
    apply_reset();
    xfer(1'b1, BASE + 32'h04, 32'h0);           // commits on tick edge 4, tick dropped
    xfer(1'b1, BASE + 32'h00, 32'hFFFF_FFFE);   // commits on edge 7
    idle(3);
    xfer(1'b1, BASE + 32'h10, 32'h2);           // stop counting at edge 13, after ticks 8 and 12
    xfer(1'b0, BASE + 32'h04, '0);
    checks++;
    if (rd4 !== 32'h1) begin errors++; $display("FAIL carry_hi got %h want 00000001", rd4); end
    xfer(1'b0, BASE + 32'h00, '0);
    checks++;
    if (rd4 !== 32'h0) begin errors++; $display("FAIL carry_lo got %h want 00000000", rd4); end
    // All ones, then run for exactly one tick (prescaler is parked at 1).
    xfer(1'b1, BASE + 32'h00, 32'hFFFF_FFFF);
    xfer(1'b1, BASE + 32'h04, 32'hFFFF_FFFF);
    xfer(1'b1, BASE + 32'h10, 32'h3);
    xfer(1'b1, BASE + 32'h10, 32'h2);
    xfer(1'b0, BASE + 32'h00, '0);
    checks++;
    if (rd4 !== 32'h0) begin errors++; $display("FAIL wrap_lo got %h want 00000000", rd4); end
    xfer(1'b0, BASE + 32'h04, '0);
    checks++;
    if (rd4 !== 32'h0) begin errors++; $display("FAIL wrap_hi got %h want 00000000", rd4); end
    idle(1);
  endtask

  task automatic test_irq();
    apply_reset();
    xfer(1'b1, BASE + 32'h0C, 32'h0);   // mtime ticks to 1 on edge 4
    xfer(1'b1, BASE + 32'h08, 32'h3);   // mtime reaches 3 on edge 12
    idle(6);
    checks++;
    if (irq4 !== 1'b0) begin errors++; $display("FAIL irq_before_match got %b want 0", irq4); end
    idle(1);
    checks++;
    if (irq4 !== 1'b1) begin errors++; $display("FAIL irq_rise got %b want 1", irq4); end
    xfer(1'b1, BASE + 32'h0C, 32'hFFFF_FFFF);
    idle(1);
    checks++;
    if (irq4 !== 1'b1) begin errors++; $display("FAIL irq_cmp_raise_early got %b want 1", irq4); end
    idle(1);
    checks++;
    if (irq4 !== 1'b0) begin errors++; $display("FAIL irq_cmp_raise_drop got %b want 0", irq4); end
    xfer(1'b1, BASE + 32'h0C, 32'h0);
    idle(2);
    checks++;
    if (irq4 !== 1'b1) begin errors++; $display("FAIL irq_rearm got %b want 1", irq4); end
    xfer(1'b1, BASE + 32'h10, 32'h1);
    idle(1);
    checks++;
    if (irq4 !== 1'b1) begin errors++; $display("FAIL irq_ctrl_early got %b want 1", irq4); end
    idle(1);
    checks++;
    if (irq4 !== 1'b0) begin errors++; $display("FAIL irq_ctrl_clear got %b want 0", irq4); end
  endtask

  task automatic test_collision();
    apply_reset();
    xfer(1'b1, BASE + 32'h00, 32'h100);  // commit edge is a tick edge for both instances
    xfer(1'b0, BASE + 32'h00, '0);
    checks++;
    if (rd1 !== 32'h101) begin errors++; $display("FAIL collision_p1 got %h want 00000101", rd1); end
    checks++;
    if (rd4 !== 32'h100) begin errors++; $display("FAIL collision_p4 got %h want 00000100", rd4); end
    idle(1);
  endtask

  task automatic test_unmapped();
    apply_reset();
    xfer(1'b1, BASE + 32'h40, 32'hDEAD_BEEF);
    xfer(1'b1, 32'h5000_0008, 32'h1234_5678);
    xfer(1'b1, BASE + 32'h50, 32'h0);
    xfer(1'b0, BASE + 32'h40, '0);
    checks++;
    if (rd4 !== 32'h0) begin errors++; $display("FAIL unmapped_read got %h want 00000000", rd4); end
    xfer(1'b0, 32'h5000_0008, '0);
    checks++;
    if (rd4 !== 32'h0) begin errors++; $display("FAIL outside_read got %h want 00000000", rd4); end
    xfer(1'b0, BASE + 32'h08, '0);
    checks++;
    if (rd4 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL unmapped_cmp_lo got %h want ffffffff", rd4); end
    xfer(1'b0, BASE + 32'h10, '0);
    checks++;
    if (rd4 !== 32'h3) begin errors++; $display("FAIL unmapped_ctrl got %h want 00000003", rd4); end
    idle(1);
  endtask

  task automatic test_back_to_back();
    xfer(1'b1, BASE + 32'h08, 32'hA5A5_0000);
    xfer(1'b0, BASE + 32'h08, '0);
    checks++;
    if (rd4 !== 32'hA5A5_0000 || rd1 !== 32'hA5A5_0000) begin
      errors++; $display("FAIL b2b_cmp_lo got %h/%h want a5a50000", rd4, rd1);
    end
    xfer(1'b1, BASE + 32'h0C, 32'h0000_1234);
    xfer(1'b0, BASE + 32'h0C, '0);
    checks++;
    if (rd4 !== 32'h0000_1234 || rd1 !== 32'h0000_1234) begin
      errors++; $display("FAIL b2b_cmp_hi got %h/%h want 00001234", rd4, rd1);
    end
    idle(1);
  endtask

  task automatic test_reset_mid_write();
    @(negedge clk);
    select = 1'b1; enable = 1'b0; write = 1'b1; addr = BASE + 32'h08; wdata = 32'h0;
    @(negedge clk);
    enable = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ready4 !== 1'b0 || ready1 !== 1'b0) begin
      errors++; $display("FAIL midwrite_ready got %b/%b want 0/0", ready4, ready1);
    end
    select = 1'b0; enable = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    xfer(1'b0, BASE + 32'h08, '0);
    checks++;
    if (rd4 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL midwrite_cmp_lo got %h want ffffffff", rd4); end
    idle(1);
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_count_carry();
    test_irq();
    test_collision();
    test_unmapped();
    test_back_to_back();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired before the test sequence completed");
    $fatal(1, "watchdog");
  end

endmodule
